// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
//
// Digit-serial two's-complement adder/subtractor. An operation processes D bits
// per clock, least-significant digit first, so a W-bit result takes N = W/D
// clocks. Subtraction is a + ~b + 1. The inverted operand and the initial
// carry of 1 are applied when the operands are captured.
//
// Parameters
//   W    operand/result width in bits (two's complement)
//   D    digit width per clock; W must be an integer multiple of D, D >= 1
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (ignored while busy)
//   sub    in   0: a+b, 1: a-b (sampled with start)
//   a, b   in   W-bit operands (sampled with start)
//   busy   out  high while digits are being processed (state RUN)
//   done   out  one-cycle pulse: r/ovf hold a new result (state DONE)
//   r      out  result register; holds between operations
//   ovf    out  signed overflow of the last completed operation
//
// Configuration
//   ADDSUB_SERIAL_SAT_EN  when defined, an overflowing result saturates to the
//                         most positive or most negative value. ovf is still
//                         reported. Ports and timing do not change.
// -----------------------------------------------------------------------------
module addsub_serial #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r,
  output logic         ovf
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [CW-1:0]  cnt;      // index of the digit processed at the next edge
  logic           carry;    // carry into the current digit
  logic [W-1:0]   a_sh;     // operand a, shifted right one digit per clock
  logic [W-1:0]   b_sh;     // effective operand b' (b or ~b), shifted likewise
  logic [W-1:0]   s_q;      // partial sum; completed digits enter at the top

  logic           accept;
  logic           last;
  logic [D:0]     dsum;
  logic [W-1:0]   s_full;
  logic           a_msb;
  logic           b_msb;
  logic           s_msb;
  logic           ovf_raw;
  logic [W-1:0]   r_nxt;

  // A start request counts only when no operation is in flight.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  // One digit of the sum. The carry out of the top digit is stored in carry
  // and then never used, because the MSB carry is discarded.
  assign dsum = {1'b0, a_sh[D-1:0]} + {1'b0, b_sh[D-1:0]} + {{D{1'b0}}, carry};

  // The partial sum after this edge. The new digit is placed at the top. After
  // N digits the least-significant digit has shifted down to bit 0.
  assign s_full = (s_q >> D) | (W'(dsum[D-1:0]) << (W - D));

  // On the final digit, the low bits of the shifters are the top digit of
  // each operand. So the digit MSBs are the operand MSBs.
  assign a_msb   = a_sh[D-1];
  assign b_msb   = b_sh[D-1];
  assign s_msb   = dsum[D-1];
  assign ovf_raw = (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);

`ifdef ADDSUB_SERIAL_SAT_EN
  // Overflow is only possible when both effective operands have the same sign.
  // The sign of a therefore gives the direction of the overflow.
  always_comb begin
    r_nxt = s_full;
    if (ovf_raw) begin
      r_nxt = a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign r_nxt = s_full;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential logic uses non-blocking assignments only. Every reader then
  // sees the pre-edge value, whatever order the always blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case. Without it, a path with no
  // assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: state_nxt = start ? RUN : IDLE;
      RUN:        if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Control state and result registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      r     <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= sub;
    end else if (state == RUN) begin
      cnt   <= cnt + CW'(1);
      carry <= dsum[D];
      if (last) begin
        r   <= r_nxt;
        ovf <= ovf_raw;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and partial-sum shifters (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers have no reset. They are always loaded on an
  // accepted start before anything reads them. Leaving out the reset keeps
  // them as plain flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b ^ {W{sub}};
      s_q  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> D;
      b_sh <= b_sh >> D;
      s_q  <= s_full;
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
//
// Bench for addsub_serial. There is a main W=16/D=4 instance and a small
// W=8/D=8 instance for the single-digit case. The driver pushes the
// reference-model result when it issues a start. A monitor pops the result
// and compares it whenever done is seen. The reference model uses plain
// signed integer arithmetic with a range check.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  typedef struct {
    logic [W-1:0] r;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic         ovf;

  logic         start8;
  logic         sub8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic         busy8;
  logic         done8;
  logic [7:0]   r8;
  logic         ovf8;

  int           n_checks = 0;
  int           n_pass   = 0;
  exp_t         sbq[$];
  logic [W-1:0] last_r   = '0;
  logic         last_v   = 1'b0;

  addsub_serial #(.W(W), .D(D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .ovf   (ovf)
  );

  addsub_serial #(.W(8), .D(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .r     (r8),
    .ovf   (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: exact signed result, then wrap or saturate to w bits.
  // Returns {ovf, r} with r in the low w bits.
  function automatic logic [32:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic s);
    int          sx, sy, res, maxv, minv;
    logic [31:0] mask, rr;
    logic        v;
    sx   = $signed(x << (32 - w)) >>> (32 - w);
    sy   = $signed(y << (32 - w)) >>> (32 - w);
    res  = s ? (sx - sy) : (sx + sy);
    maxv = (1 << (w - 1)) - 1;
    minv = -(1 << (w - 1));
    mask = (1 << w) - 1;
    v    = (res > maxv) || (res < minv);
    rr   = res & mask;
`ifdef ADDSUB_SERIAL_SAT_EN
    if (v) rr = ((res > maxv) ? maxv : minv) & mask;
`endif
    return {v, rr};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result_r", r, e.r);
        check("result_ovf", ovf, e.v);
        last_r = e.r;
        last_v = e.v;
      end
    end
  end

  // Call at a negedge. Returns at the negedge of the expected DONE cycle
  // with start low. A junk start with all-ones operands is pulsed mid-RUN
  // when requested.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input bit junk);
    logic [32:0] m;
    m = model(W, 32'(ta), 32'(tb_v), ts);
    sbq.push_back('{r: m[W-1:0], v: m[32]});
    start = 1'b1; a = ta; b = tb_v; sub = ts;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("busy_run", busy, 1);
      check("r_hold_run", r, last_r);
      if (junk && i == 1) begin
        start = 1'b1; a = '1; b = '1; sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_r_hold", r, last_r);
      check("idle_ovf_hold", ovf, last_v);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [32:0] m8;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state, checked before the first clock edge.
    #1;
    check("rst_r", r, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Directed operations.
    run_op(16'h1234, 16'h0001, 1'b0, 1'b0); idle(1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle(1);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0); idle(1);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0); idle(2);

    // Ignored start during RUN, then back-to-back starts.
    run_op(16'h0100, 16'h0023, 1'b0, 1'b1);
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b1, 1'b1);
    idle(1);

    // Randomized operations with random gaps (zero gap means back-to-back).
    for (int k = 0; k < 40; k++) begin
      run_op(pick(), pick(), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Asynchronous reset mid-RUN aborts the operation.
    start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_r", r, 0);
    check("abort_ovf", ovf, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    last_r = '0;
    last_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(N + 2);

    // Single-digit instance: done one clock after start.
    m8 = model(8, 32'h7F, 32'h7F, 1'b0);
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; sub8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("n1_busy", busy8, 1);
    check("n1_done_early", done8, 0);
    @(posedge clk);
    @(negedge clk);
    check("n1_done", done8, 1);
    check("n1_r", r8, m8[7:0]);
    check("n1_ovf", ovf8, m8[32]);
    @(negedge clk);
    check("n1_done_once", done8, 0);

    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d results outstanding, expected 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
